// File: rtl/cipher_unpacker_pkg.sv
// Shared definitions for the receive-side cipher unpacker: FSM encoding,
// block geometry and the mode constants shared with the output stage.
package cipher_unpacker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_LAUNCH  = 2'd2,
    ST_WAIT    = 2'd3
  } state_t;

  localparam int BEATS_PER_BLK = 4;
  localparam int CNT_W         = $clog2(BEATS_PER_BLK);

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  function automatic int gap_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/cipher_unpacker_beat_deserializer.sv
// Assembles four stream beats into one block, MSB slice first, and times the
// idle gap between beats so a stalled partial frame can be discarded.
module cipher_unpacker_beat_deserializer
  import cipher_unpacker_pkg::*;
#(
  parameter int BEAT_BW     = 64,
  parameter int GAP_TIMEOUT = 16
) (
  input  logic                             clk,
  input  logic                             srst,
  input  logic                             i_collect,
  input  logic                             i_accept,
  input  logic [BEAT_BW-1:0]               i_data,
  output logic [BEATS_PER_BLK*BEAT_BW-1:0] o_block,
  output logic                             o_last_beat,
  output logic                             o_timeout
);

  localparam int               GAP_W    = gap_width(GAP_TIMEOUT);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(GAP_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS_PER_BLK - 1);

  logic [CNT_W-1:0]               r_cnt;
  logic [GAP_W-1:0]               r_gap;
  logic [BEATS_PER_BLK*BEAT_BW-1:0] r_block;
  logic [CNT_W-1:0]               w_slice;

  // Beat n lands in slice (3-n), so beat 0 ends up in the top 64 bits.
  assign w_slice     = CNT_LAST - r_cnt;
  assign o_timeout   = i_collect && (r_gap == GAP_MAX);
  assign o_last_beat = i_accept && (r_cnt == CNT_LAST);
  assign o_block     = r_block;

  always_ff @(posedge clk) begin
    if (srst) begin
      r_cnt   <= '0;
      r_gap   <= '0;
      r_block <= '0;
    end else if (o_timeout) begin
      r_cnt   <= '0;
      r_gap   <= '0;
      r_block <= '0;
    end else if (i_accept) begin
      for (int s = 0; s < BEATS_PER_BLK; s++) begin
        if (w_slice == CNT_W'(s)) r_block[s*BEAT_BW +: BEAT_BW] <= i_data;
      end
      r_cnt <= r_cnt + 1'b1;
      r_gap <= '0;
    end else if (i_collect) begin
      if (r_gap != GAP_MAX) r_gap <= r_gap + 1'b1;
    end else begin
      r_gap <= '0;
    end
  end

endmodule

// File: rtl/cipher_unpacker.sv
// Receive-side cipher unpacker: gathers a 256-bit block from 64-bit beats,
// launches the MSB/LSB AES cores together and reports joint completion.
module cipher_unpacker
  import cipher_unpacker_pkg::*;
#(
  parameter int AES_TXT_BW  = 128,
  parameter int BEAT_BW     = 64,
  parameter int GAP_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  mode_i,
  input  logic                  in_valid,
  input  logic [BEAT_BW-1:0]    in_data,
  output logic                  in_ready,
  output logic [AES_TXT_BW-1:0] aes_msb_i,
  output logic [AES_TXT_BW-1:0] aes_lsb_i,
  output logic                  aes_mode,
  output logic                  aes_start,
  input  logic                  aes_msb_done,
  input  logic                  aes_lsb_done,
  output logic                  blk_done,
  output logic                  frame_err,
  output state_t                dbg_state
);

  localparam int BLK_BW = BEATS_PER_BLK * BEAT_BW;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_mode;
  logic               r_msb_flag;
  logic               r_lsb_flag;
  logic               w_in_ready;
  logic               w_accept;
  logic               w_start;
  logic               w_blk_done;
  logic               w_msb_seen;
  logic               w_lsb_seen;
  logic               w_last_beat;
  logic               w_timeout;
  logic [BLK_BW-1:0]  w_block;

  // A beat transfers on a cycle where in_valid and in_ready are both high;
  // upstream holds in_data stable until then, so in_ready low never loses data.
  assign w_in_ready = !srst && ((r_state == ST_IDLE) ||
                                ((r_state == ST_COLLECT) && !w_timeout));
  assign w_accept   = in_valid && w_in_ready;
  assign w_msb_seen = r_msb_flag || aes_msb_done;
  assign w_lsb_seen = r_lsb_flag || aes_lsb_done;

  cipher_unpacker_beat_deserializer #(
    .BEAT_BW     (BEAT_BW),
    .GAP_TIMEOUT (GAP_TIMEOUT)
  ) u_deser (
    .clk         (clk),
    .srst        (srst),
    .i_collect   (r_state == ST_COLLECT),
    .i_accept    (w_accept),
    .i_data      (in_data),
    .o_block     (w_block),
    .o_last_beat (w_last_beat),
    .o_timeout   (w_timeout)
  );

  always_ff @(posedge clk) begin
    if (srst) begin
      r_state    <= ST_IDLE;
      r_mode     <= MODE_ENC;
      r_msb_flag <= 1'b0;
      r_lsb_flag <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_IDLE) && w_accept) r_mode <= mode_i;
      if (r_state == ST_LAUNCH) begin
        r_msb_flag <= 1'b0;
        r_lsb_flag <= 1'b0;
      end else if (r_state == ST_WAIT) begin
        r_msb_flag <= w_msb_seen;
        r_lsb_flag <= w_lsb_seen;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_blk_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (w_timeout)        w_state_nxt = ST_IDLE;
        else if (w_last_beat) w_state_nxt = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        w_start     = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_msb_seen && w_lsb_seen) begin
          w_blk_done  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Pulses are masked during reset so an interrupted operation emits nothing.
  assign in_ready  = w_in_ready;
  assign aes_start = w_start && !srst;
  assign blk_done  = w_blk_done && !srst;
  assign frame_err = w_timeout && !srst;
  assign aes_msb_i = w_block[BLK_BW-1 -: AES_TXT_BW];
  assign aes_lsb_i = w_block[AES_TXT_BW-1:0];
  assign aes_mode  = r_mode;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_cipher_unpacker.sv
// Directed bench for cipher_unpacker: queue-based frame model checked every
// cycle, plus literal expectations for each scenario.
module tb_cipher_unpacker;
  import cipher_unpacker_pkg::*;

  localparam int AES_TXT_BW  = 128;
  localparam int BEAT_BW     = 64;
  localparam int GAP_TIMEOUT = 16;

  logic                  clk = 1'b0;
  logic                  srst;
  logic                  mode_i;
  logic                  in_valid;
  logic [BEAT_BW-1:0]    in_data;
  logic                  in_ready;
  logic [AES_TXT_BW-1:0] aes_msb_i;
  logic [AES_TXT_BW-1:0] aes_lsb_i;
  logic                  aes_mode;
  logic                  aes_start;
  logic                  aes_msb_done;
  logic                  aes_lsb_done;
  logic                  blk_done;
  logic                  frame_err;
  state_t                dbg_state;

  cipher_unpacker #(
    .AES_TXT_BW  (AES_TXT_BW),
    .BEAT_BW     (BEAT_BW),
    .GAP_TIMEOUT (GAP_TIMEOUT)
  ) dut (
    .clk          (clk),
    .srst         (srst),
    .mode_i       (mode_i),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .aes_msb_i    (aes_msb_i),
    .aes_lsb_i    (aes_lsb_i),
    .aes_mode     (aes_mode),
    .aes_start    (aes_start),
    .aes_msb_done (aes_msb_done),
    .aes_lsb_done (aes_lsb_done),
    .blk_done     (blk_done),
    .frame_err    (frame_err),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- counters / observations ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_acc    = 0;
  int n_start  = 0;
  int n_done   = 0;
  int n_err    = 0;
  int last_beat_cyc  = 0;
  int last_start_cyc = 0;
  int last_done_cyc  = 0;
  int lsb_d = 1;
  int msb_d = 1;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model / scoreboard ----------------
  logic [BEAT_BW-1:0] exp_q[$];   // beats of the frame being assembled
  int                 m_stage = 0; // 0 accepting, 1 launch cycle, 2 awaiting cores
  int                 m_gap   = 0;
  logic [255:0]       m_blk   = '0;
  logic               m_mode  = 1'b0;
  logic               m_msb_seen = 1'b0;
  logic               m_lsb_seen = 1'b0;

  task automatic model_step();
    logic e_ready, e_start, e_done, e_err, tmo, acc, ms, ls;
    logic [1:0] e_state;
    e_ready = 1'b0; e_start = 1'b0; e_done = 1'b0; e_err = 1'b0;
    tmo = 1'b0; ms = 1'b0; ls = 1'b0;
    if (srst) begin
      check("rst_in_ready",  in_ready,  1'b0);
      check("rst_aes_start", aes_start, 1'b0);
      check("rst_blk_done",  blk_done,  1'b0);
      check("rst_frame_err", frame_err, 1'b0);
      exp_q.delete();
      m_stage = 0; m_gap = 0; m_blk = '0; m_mode = 1'b0;
      m_msb_seen = 1'b0; m_lsb_seen = 1'b0;
      return;
    end
    e_state = (m_stage == 1) ? 2'd2 : (m_stage == 2) ? 2'd3 :
              (exp_q.size() > 0) ? 2'd1 : 2'd0;
    if (m_stage != 0 || exp_q.size() == 0) begin
      check("aes_msb_i", aes_msb_i, m_blk[255:128]);
      check("aes_lsb_i", aes_lsb_i, m_blk[127:0]);
      check("aes_mode",  aes_mode,  m_mode);
    end
    case (m_stage)
      0: begin
        tmo     = (exp_q.size() > 0) && (m_gap == GAP_TIMEOUT);
        e_ready = !tmo;
        e_err   = tmo;
      end
      1: e_start = 1'b1;
      default: begin
        ms     = m_msb_seen || aes_msb_done;
        ls     = m_lsb_seen || aes_lsb_done;
        e_done = ms && ls;
      end
    endcase
    check("in_ready",  in_ready,  e_ready);
    check("aes_start", aes_start, e_start);
    check("blk_done",  blk_done,  e_done);
    check("frame_err", frame_err, e_err);
    check("state",     dbg_state, e_state);

    if (in_valid && in_ready) begin n_acc++; last_beat_cyc = cyc; end
    if (aes_start) begin n_start++; last_start_cyc = cyc; end
    if (blk_done)  begin n_done++;  last_done_cyc  = cyc; end
    if (frame_err) n_err++;

    acc = in_valid && e_ready;
    case (m_stage)
      0: begin
        if (tmo) begin
          exp_q.delete(); m_blk = '0; m_gap = 0;
        end else if (acc) begin
          if (exp_q.size() == 0) m_mode = mode_i;
          exp_q.push_back(in_data);
          m_gap = 0;
          if (exp_q.size() == 4) begin
            m_blk = {exp_q[0], exp_q[1], exp_q[2], exp_q[3]};
            exp_q.delete();
            m_stage = 1;
          end
        end else if (exp_q.size() > 0) begin
          m_gap++;
        end
      end
      1: begin
        m_msb_seen = 1'b0; m_lsb_seen = 1'b0; m_stage = 2;
      end
      default: begin
        m_msb_seen = ms; m_lsb_seen = ls;
        if (ms && ls) m_stage = 0;
      end
    endcase
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      model_step();
    end
  end

  // ---------------- AES core responder ----------------
  initial begin
    aes_msb_done = 1'b0;
    aes_lsb_done = 1'b0;
    forever begin
      @(negedge clk);
      if (aes_start) begin
        for (int k = 1; k <= ((lsb_d > msb_d) ? lsb_d : msb_d); k++) begin
          @(posedge clk); #1;
          aes_lsb_done = (k == lsb_d);
          aes_msb_done = (k == msb_d);
        end
        @(posedge clk); #1;
        aes_lsb_done = 1'b0;
        aes_msb_done = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_beat(input logic [BEAT_BW-1:0] d, input logic m);
    int k;
    in_valid = 1'b1; in_data = d; mode_i = m;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    check("send_beat_handshake", in_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [BEAT_BW-1:0] b0, input logic [BEAT_BW-1:0] b1,
                            input logic [BEAT_BW-1:0] b2, input logic [BEAT_BW-1:0] b3,
                            input logic m);
    send_beat(b0, m);
    send_beat(b1, ~m);
    send_beat(b2, ~m);
    send_beat(b3, ~m);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int base);
    for (int k = 0; k < 200; k++) begin
      if (n_done > base) break;
      tick(1);
    end
    check("wait_done_bound", (n_done > base), 1'b1);
  endtask

  // ---------------- directed scenarios ----------------
  localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;

  int s_base, d_base, e_base, a_base, beat4_cyc;

  initial begin
    srst = 1'b1; in_valid = 1'b0; in_data = '0; mode_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 srst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_msb_zero", aes_msb_i, 128'h0);
    check("reset_mode_zero", aes_mode, 1'b0);
    tick(1);

    // Back-to-back frame, mode 1 on beat 0 only.
    s_base = n_start; d_base = n_done;
    send_frame(B1, B2, B3, B4, 1'b1);
    wait_done(d_base);
    check("t1_msb", aes_msb_i, {B1, B2});
    check("t1_lsb", aes_lsb_i, {B3, B4});
    check("t1_mode", aes_mode, 1'b1);
    check("t1_start_latency", last_start_cyc - last_beat_cyc, 1);
    check("t1_start_count", n_start - s_base, 1);
    tick(2);

    // Split completions.
    lsb_d = 3; msb_d = 7; d_base = n_done;
    send_frame(64'hA5A5_0000_0000_0001, 64'hA5A5_0000_0000_0002,
               64'hA5A5_0000_0000_0003, 64'hA5A5_0000_0000_0004, 1'b0);
    wait_done(d_base);
    check("t2_done_after_msb", last_done_cyc - last_start_cyc, 7);
    check("t2_done_count", n_done - d_base, 1);
    @(negedge clk);
    check("t2_ready_after", in_ready, 1'b1);
    tick(1);
    lsb_d = 1; msb_d = 1;

    // Gap timeout discards a partial frame.
    s_base = n_start; e_base = n_err;
    send_beat(64'hDEAD_0000_0000_0000, 1'b1);
    send_beat(64'hDEAD_1111_0000_0000, 1'b1);
    in_valid = 1'b0;
    tick(20);
    check("t3_err_count", n_err - e_base, 1);
    check("t3_no_start", n_start - s_base, 0);
    d_base = n_done;
    send_frame(64'hC0DE_0001_0000_0000, 64'hC0DE_0002_0000_0000,
               64'hC0DE_0003_0000_0000, 64'hC0DE_0004_0000_0000, 1'b0);
    wait_done(d_base);
    check("t3_msb", aes_msb_i, {64'hC0DE_0001_0000_0000, 64'hC0DE_0002_0000_0000});
    check("t3_start_count", n_start - s_base, 1);
    tick(2);

    // Gap one short of the limit.
    s_base = n_start; e_base = n_err; d_base = n_done;
    send_beat(64'h0F0F_0000_0000_0001, 1'b0);
    send_beat(64'h0F0F_0000_0000_0002, 1'b0);
    in_valid = 1'b0;
    tick(15);
    send_beat(64'h0F0F_0000_0000_0003, 1'b1);
    send_beat(64'h0F0F_0000_0000_0004, 1'b1);
    in_valid = 1'b0;
    wait_done(d_base);
    check("t4_no_err", n_err - e_base, 0);
    check("t4_start_count", n_start - s_base, 1);
    check("t4_lsb", aes_lsb_i, {64'h0F0F_0000_0000_0003, 64'h0F0F_0000_0000_0004});
    check("t4_mode", aes_mode, 1'b0);
    tick(2);

    // Continuous valid across two frames.
    a_base = n_acc; s_base = n_start; d_base = n_done;
    send_beat(64'h5000_0000_0000_0000, 1'b1);
    send_beat(64'h5000_0000_0000_0001, 1'b0);
    send_beat(64'h5000_0000_0000_0002, 1'b0);
    send_beat(64'h5000_0000_0000_0003, 1'b0);
    beat4_cyc = last_beat_cyc;
    send_beat(64'h6000_0000_0000_0000, 1'b0);
    check("t5_beat5_after_done", last_beat_cyc - beat4_cyc, 3);
    send_beat(64'h6000_0000_0000_0001, 1'b1);
    send_beat(64'h6000_0000_0000_0002, 1'b1);
    send_beat(64'h6000_0000_0000_0003, 1'b1);
    in_valid = 1'b0;
    wait_done(d_base + 1);
    check("t5_beats_consumed", n_acc - a_base, 8);
    check("t5_start_count", n_start - s_base, 2);
    check("t5_lsb", aes_lsb_i, {64'h6000_0000_0000_0002, 64'h6000_0000_0000_0003});
    tick(2);

    // Reset after the third beat.
    s_base = n_start;
    send_beat(64'h7777_0000_0000_0000, 1'b1);
    send_beat(64'h7777_0000_0000_0001, 1'b1);
    send_beat(64'h7777_0000_0000_0002, 1'b1);
    in_valid = 1'b0;
    srst = 1'b1;
    tick(1);
    srst = 1'b0;
    @(negedge clk);
    check("t6_ready_after_rst", in_ready, 1'b1);
    tick(3);
    check("t6_no_start", n_start - s_base, 0);
    d_base = n_done;
    send_frame(64'h8888_0000_0000_0000, 64'h8888_0000_0000_0001,
               64'h8888_0000_0000_0002, 64'h8888_0000_0000_0003, 1'b1);
    wait_done(d_base);
    check("t6_msb", aes_msb_i, {64'h8888_0000_0000_0000, 64'h8888_0000_0000_0001});
    check("t6_mode", aes_mode, 1'b1);
    check("t6_start_count", n_start - s_base, 1);
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
